disp_scan_mux: RTL and testbench
================================

// Module: disp_scan_mux
// PURPOSE
//  Upstream feeder for the 4-bit-to-7-segment decoder (nibble -> decoder sw[3:0]).
//  Time-multiplexes a DIGITS-wide hex value onto one shared decoder and drives active-low digit enables.
//  Double-buffers writes so a value changes only at a frame boundary, which prevents digit tearing.
//  Inserts guard (blank) cycles at each digit switch, which suppresses ghosting.
// PARAMETERS
//  DIGITS    4      number of multiplexed digits (2..8)
//  PRESCALE  50000  clk cycles per digit slot (>= GUARD+2)
//  GUARD     2      blank cycles at start of each slot, all enables off (>= 1)
// PORTS
//  clk         in   1           system clock, rising edge
//  rst_n       in   1           asynchronous reset, active low
//  load        in   1           1-cycle write strobe for value
//  value       in   4*DIGITS    hex digits, digit k = value[4k+3:4k], digit 0 rightmost
//  nibble      out  4           current digit code, wired to decoder sw input
//  an_n        out  DIGITS      digit enables, active low, at most one low at a time
//  frame_tick  out  1           1-cycle pulse at start of every frame
//  upd_ack     out  1           1-cycle pulse when a pending value becomes displayed
// BEHAVIOUR
//  Reset (async, immediate, all regs):
//   - cnt=0, idx=0, disp=0, pend=0, pend_v=0
//   - an_n=all 1, nibble=0, frame_tick=0, upd_ack=0
//  Prescaler: cnt counts 0..PRESCALE-1, then wraps to 0. slot_end = (cnt==PRESCALE-1).
//  Digit index: idx advances on slot_end and wraps DIGITS-1 -> 0.
//   - Frame = DIGITS*PRESCALE cycles.
//  Outputs are registered from next-state:
//   - In a cycle whose cnt is in [0,GUARD-1]: an_n = all 1.
//   - In a cycle whose cnt is in [GUARD,PRESCALE-1]: an_n[idx]=0, others 1.
//   - nibble = disp[4*idx +: 4] for the whole slot, so it is stable before the enable asserts.
//  Write path:
//   - load=1 captures value into pend and sets pend_v.
//   - Repeated loads in one frame: last one wins, one ack only.
//  Apply:
//   - On the edge where idx wraps DIGITS-1 -> 0 and pend_v=1: disp<=pend, pend_v<=0, upd_ack=1 for one cycle.
//   - The first slot of the new frame already shows the new value.
//  Simultaneous load and apply on the same edge:
//   - The old pend is applied.
//   - The new value is captured and pend_v stays 1 for the next frame.
//  frame_tick: 1 in the first cycle of each frame (cnt=0, idx=0), including the first cycle after reset release.
//  Reset mid-frame:
//   - an_n goes all-1 immediately.
//   - pending write is discarded.
//   - scan restarts at digit 0.
//  Arithmetic:
//   - cnt width = $clog2(PRESCALE), idx width = $clog2(DIGITS) (min 1).
//   - No counter may exceed its terminal value.
// CONFIGURATION
//  LZ_BLANK_EN defined (leading-zero blanking):
//   - Digit k > 0 stays blanked (an_n[k]=1 all slot) when disp digits k..DIGITS-1 are all zero.
//   - Digit 0 is never blanked, so value 0 shows a single "0".
//   - Blank mask is evaluated from disp only, so it updates only at frame boundaries.
//  LZ_BLANK_EN undefined:
//   - All digits are always shown.
//   - No blanking logic is synthesised.
// TESTING (DIGITS=4, PRESCALE=8, GUARD=2)
//  1. rst_n=0 -> an_n=4'b1111, nibble=0, frame_tick=0, upd_ack=0.
//     Release -> frame_tick=1 first cycle, an_n=4'b1111 for 2 cycles, then 4'b1110 for 6 cycles.
//  2. load 16'h1234 during idx=2 -> upd_ack pulses once, at the idx 3->0 wrap.
//     Next frame nibble = 4,3,2,1 with an_n = 1110,1101,1011,0111.
//  3. load 16'hAAAA then 16'h5A0F in the same frame -> single upd_ack; display shows 5A0F.
//     load on the apply edge -> that value shows one frame later, with a second ack.
//  4. Assert rst_n mid-slot (idx=2, cnt=5) -> an_n=4'b1111 same cycle, pending write lost, scan restarts at digit 0.
//  5. Free-run 10 frames -> frame_tick period exactly 32 cycles.
//     Never more than one an_n bit low; every slot has 2 all-high guard cycles.
//  6. LZ_BLANK_EN with 16'h0040 -> digits 3,2 blanked, digit 1 shows 4, digit 0 shows 0.
//     With 16'h0000 -> only digit 0 enabled.

Source files
------------

// File: rtl/disp_scan_mux_if.sv
// disp_scan_mux_if
//   Bundles the write strobe/value and the scan outputs of disp_scan_mux.
//   master : the writer/observer (drives load, value; receives scan outputs)
//   slave  : the scan multiplexer itself
//   load       1-cycle write strobe for value
//   value      4*DIGITS hex digits, digit 0 rightmost
//   nibble     current digit code for the shared 7-segment decoder
//   an_n       active-low digit enables
//   frame_tick 1-cycle pulse at the start of every frame
//   upd_ack    1-cycle pulse when a pending value becomes displayed
interface disp_scan_mux_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [3:0]            nibble;
  logic [DIGITS-1:0]     an_n;
  logic                  frame_tick;
  logic                  upd_ack;

  modport master (
    output load, value,
    input  nibble, an_n, frame_tick, upd_ack
  );

  modport slave (
    input  load, value,
    output nibble, an_n, frame_tick, upd_ack
  );
endinterface

// File: rtl/disp_scan_mux.sv
// disp_scan_mux
//   Time-multiplexes a DIGITS-wide hex value onto one shared 4-bit-to-7-segment
//   decoder. Writes are double-buffered and applied only at a frame boundary,
//   and every digit slot begins with GUARD blank cycles to suppress ghosting.
// Ports
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous reset, active low
//   bus    slave side of disp_scan_mux_if (load/value in; nibble, an_n,
//          frame_tick, upd_ack out, all registered)
// Configuration
//   LZ_BLANK_EN : when defined, leading-zero digits (k > 0) are blanked.
module disp_scan_mux #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  disp_scan_mux_if.slave  bus
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW = 4 * DIGITS;

  localparam logic [CW-1:0]     CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]     GUARD_C  = CW'(GUARD);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [IW-1:0]     IDX_ONE  = IW'(1);
  localparam logic [DIGITS-1:0] SEL_ONE  = DIGITS'(1);

`ifdef LZ_BLANK_EN
  // Digit k > 0 is blanked when it and every digit above it are zero.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [VW-1:0] d);
    logic [DIGITS-1:0] m;
    logic              nz;
    m  = '0;
    nz = 1'b0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      nz   = nz | (|d[4*k +: 4]);
      m[k] = ~nz;
    end
    return m;
  endfunction
`endif

  // run_q holds the scan at (cnt=0, idx=0) for the first edge after reset so
  // that the first visible cycle is a full frame-start cycle.
  logic              run_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [VW-1:0]     disp_q, disp_d;
  logic [VW-1:0]     pend_q, pend_d;
  logic              pend_v_q, pend_v_d;
  logic [DIGITS-1:0] an_n_q, an_n_d;
  logic [3:0]        nibble_q, nibble_d;
  logic              frame_tick_q, frame_tick_d;
  logic              upd_ack_q, upd_ack_d;

  logic              slot_end_s;
  logic              apply_s;
  logic [DIGITS-1:0] blank_s;
  logic [DIGITS-1:0] sel_s;

  // Next-state: prescaler, digit index, write buffer and registered outputs.
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    disp_d       = disp_q;
    pend_d       = pend_q;
    pend_v_d     = pend_v_q;
    slot_end_s   = run_q && (cnt_q == CNT_LAST);
    apply_s      = slot_end_s && (idx_q == IDX_LAST) && pend_v_q;

    if (!run_q) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (slot_end_s) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_ONE;
      end
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    // Apply uses the old buffer; a load on the same edge refills it.
    if (apply_s) begin
      disp_d = pend_q;
    end else begin
      disp_d = disp_q;
    end

    if (bus.load) begin
      pend_d   = bus.value;
      pend_v_d = 1'b1;
    end else if (apply_s) begin
      pend_v_d = 1'b0;
    end else begin
      pend_v_d = pend_v_q;
    end

`ifdef LZ_BLANK_EN
    blank_s = lz_mask(disp_d);
`else
    blank_s = '0;
`endif

    // Outputs describe the cycle the scan is entering, hence the _d terms.
    sel_s    = SEL_ONE << idx_d;
    nibble_d = 4'(disp_d >> {idx_d, 2'b00});
    if ((cnt_d >= GUARD_C) && ((sel_s & blank_s) == '0)) begin
      an_n_d = ~sel_s;
    end else begin
      an_n_d = '1;
    end
    frame_tick_d = (cnt_d == '0) && (idx_d == '0);
    upd_ack_d    = apply_s;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q        <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_v_q     <= 1'b0;
      an_n_q       <= '1;
      nibble_q     <= 4'h0;
      frame_tick_q <= 1'b0;
      upd_ack_q    <= 1'b0;
    end else begin
      run_q        <= 1'b1;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      an_n_q       <= an_n_d;
      nibble_q     <= nibble_d;
      frame_tick_q <= frame_tick_d;
      upd_ack_q    <= upd_ack_d;
    end
  end

  assign bus.an_n       = an_n_q;
  assign bus.nibble     = nibble_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.upd_ack    = upd_ack_q;

endmodule

// File: tb/tb_disp_scan_mux.sv
// tb_disp_scan_mux
//   Drives disp_scan_mux (DIGITS=4, PRESCALE=8, GUARD=2) and compares every
//   cycle against a frame/slot arithmetic model of the display.
module tb_disp_scan_mux;
  localparam int DIG   = 4;
  localparam int PRE   = 8;
  localparam int GRD   = 2;
  localparam int FRAME = DIG * PRE;

  logic clk;
  logic rst_n;

  disp_scan_mux_if #(.DIGITS(DIG)) bus();

  disp_scan_mux #(.DIGITS(DIG), .PRESCALE(PRE), .GUARD(GRD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks;
  int errors;

  // Reference model: cycle number since the first frame, plus buffers.
  bit          m_run;
  int          m_cyc;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  bit          m_pend_v;
  bit          m_ack;

  always #5 clk = ~clk;

  function automatic logic [9:0] exp_vec();
    int          slot;
    int          pos;
    logic [3:0]  an;
    logic [15:0] upper;
    slot  = (m_cyc / PRE) % DIG;
    pos   = m_cyc % PRE;
    upper = m_disp >> (4 * slot);
    an    = 4'hF;
    if (pos >= GRD) an[slot] = 1'b0;
`ifdef LZ_BLANK_EN
    if (slot > 0 && upper == 16'h0000) an = 4'hF;
`endif
    return {an, upper[3:0], (m_cyc % FRAME) == 0, m_ack};
  endfunction

  function automatic logic [9:0] obs_vec();
    return {bus.an_n, bus.nibble, bus.frame_tick, bus.upd_ack};
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_cyc = 0; m_disp = 16'h0; m_pend = 16'h0;
    m_pend_v = 1'b0; m_ack = 1'b0;
  endtask

  // One clock: drive inputs, advance the model on the edge, land on negedge.
  task automatic step(input logic ld, input logic [15:0] v);
    bus.load  = ld;
    bus.value = v;
    @(posedge clk);
    m_ack = 1'b0;
    if (!m_run) begin
      m_run = 1'b1;
      m_cyc = 0;
    end else begin
      m_cyc++;
      if ((m_cyc % FRAME) == 0 && m_pend_v) begin
        m_disp = m_pend; m_pend_v = 1'b0; m_ack = 1'b1;
      end
    end
    if (ld) begin
      m_pend = v; m_pend_v = 1'b1;
    end
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] want_an;
    rst_n = 1'b0; bus.load = 1'b0; bus.value = 16'h0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs_vec() !== {4'hF, 4'h0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_state: got %b want %b", obs_vec(), {4'hF, 4'h0, 1'b0, 1'b0});
    end
    rst_n = 1'b1;
    for (int i = 0; i < PRE; i++) begin
      step(1'b0, 16'h0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_release cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
      want_an = (i < GRD) ? 4'hF : 4'hE;
      checks++;
      if (bus.an_n !== want_an || bus.frame_tick !== (i == 0)) begin
        errors++; $display("FAIL first_slot cyc %0d: an_n %b tick %b want %b %b", i, bus.an_n, bus.frame_tick, want_an, i == 0);
      end
    end
  endtask

  task automatic test_load_basic();
    int acks;
    acks = 0;
    while ((m_cyc % FRAME) != 18) begin
      step(1'b0, 16'h0); checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL load_nav: got %b want %b", obs_vec(), exp_vec()); end
    end
    step(1'b1, 16'h1234);
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 16'h0); checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL load_basic: got %b want %b", obs_vec(), exp_vec()); end
      if (bus.upd_ack === 1'b1) begin
        acks++; checks++;
        if (bus.nibble !== 4'h4 || bus.an_n !== 4'hF) begin
          errors++; $display("FAIL load_first_digit: nibble %h an_n %b want 4 1111", bus.nibble, bus.an_n);
        end
      end
    end
    checks++;
    if (acks !== 1) begin errors++; $display("FAIL load_ack_count: got %0d want 1", acks); end
  endtask

  task automatic test_last_wins();
    int acks;
    acks = 0;
    while ((m_cyc % FRAME) != 3) begin
      step(1'b0, 16'h0); checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL lw_nav: got %b want %b", obs_vec(), exp_vec()); end
    end
    step(1'b1, 16'hAAAA);
    while ((m_cyc % FRAME) != 10) step(1'b0, 16'h0);
    step(1'b1, 16'h5A0F);
    while ((m_cyc % FRAME) != FRAME - 1) begin
      step(1'b0, 16'h0); checks++;
      if (bus.upd_ack !== 1'b0) begin errors++; $display("FAIL lw_early_ack: got %b want 0", bus.upd_ack); end
    end
    step(1'b1, 16'h3C3C);   // load on the apply edge
    for (int i = 0; i < 2 * FRAME + 1; i++) begin
      if (i > 0) step(1'b0, 16'h0);
      checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL last_wins: got %b want %b", obs_vec(), exp_vec()); end
      if (bus.upd_ack === 1'b1) begin
        acks++; checks++;
        if (bus.nibble !== ((acks == 1) ? 4'hF : 4'hC)) begin
          errors++; $display("FAIL lw_applied_digit ack %0d: got %h want %h", acks, bus.nibble, (acks == 1) ? 4'hF : 4'hC);
        end
      end
    end
    checks++;
    if (acks !== 2) begin errors++; $display("FAIL lw_ack_count: got %0d want 2", acks); end
  endtask

  task automatic test_reset_mid();
    int acks;
    acks = 0;
    while ((m_cyc % FRAME) != 5) step(1'b0, 16'h0);
    step(1'b1, 16'hBEEF);
    while ((m_cyc % FRAME) != 2 * PRE + 5) step(1'b0, 16'h0);
    checks++;
    if (bus.an_n !== 4'hB) begin errors++; $display("FAIL mid_pre_reset: an_n %b want 1011", bus.an_n); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== {4'hF, 4'h0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL mid_reset_async: got %b want %b", obs_vec(), {4'hF, 4'h0, 1'b0, 1'b0});
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 16'h0); checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL reset_mid: got %b want %b", obs_vec(), exp_vec()); end
      if (bus.upd_ack === 1'b1) acks++;
    end
    checks++;
    if (acks !== 0) begin errors++; $display("FAIL mid_lost_write acks: got %0d want 0", acks); end
  endtask

  task automatic test_free_run();
    int last_tick;
    logic [15:0] v;
    last_tick = -1;
    for (int i = 0; i < 10 * FRAME; i++) begin
      v = 16'($urandom);
      step($urandom_range(7, 0) == 0, v);
      checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL free_run cyc %0d: got %b want %b", i, obs_vec(), exp_vec()); end
      checks++;
      if ($countones(~bus.an_n) > 1) begin errors++; $display("FAIL one_hot: an_n %b want at most one low", bus.an_n); end
      if (bus.frame_tick === 1'b1) begin
        if (last_tick >= 0) begin
          checks++;
          if (i - last_tick !== FRAME) begin errors++; $display("FAIL tick_period: got %0d want %0d", i - last_tick, FRAME); end
        end
        last_tick = i;
      end
    end
  endtask

`ifdef LZ_BLANK_EN
  task automatic test_lz_blank();
    logic [15:0] vals [2];
    logic [3:0]  keep [2];
    vals[0] = 16'h0040; keep[0] = 4'b1100;
    vals[1] = 16'h0000; keep[1] = 4'b1110;
    for (int t = 0; t < 2; t++) begin
      while ((m_cyc % FRAME) != 7) step(1'b0, 16'h0);
      step(1'b1, vals[t]);
      while ((m_cyc % FRAME) != FRAME - 1) step(1'b0, 16'h0);
      for (int i = 0; i < FRAME; i++) begin
        step(1'b0, 16'h0); checks++;
        if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL lz_model: got %b want %b", obs_vec(), exp_vec()); end
        checks++;
        if ((bus.an_n & keep[t]) !== keep[t]) begin
          errors++; $display("FAIL lz_blank %h: an_n %b want bits %b high", vals[t], bus.an_n, keep[t]);
        end
      end
    end
  endtask
`endif

  initial begin
    clk = 1'b0; checks = 0; errors = 0;
    test_reset();
    test_load_basic();
    test_last_wins();
    test_reset_mid();
    test_free_run();
`ifdef LZ_BLANK_EN
    test_lz_blank();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
